// File: rtl/spi_master_if.sv
// Host-side request/response bundle for spi_master.
// master: local controller side; slave: the spi_master block.
interface spi_master_if;
  logic       start;
  logic       rw;
  logic       burst;
  logic [3:0] len;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       wdata_ack;
  logic [7:0] rdata;
  logic       rdata_vld;
  logic       busy;
  logic       done;

  modport master (
    output start, rw, burst, len, addr, wdata,
    input  wdata_ack, rdata, rdata_vld, busy, done
  );

  modport slave (
    input  start, rw, burst, len, addr, wdata,
    output wdata_ack, rdata, rdata_vld, busy, done
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator: cmd + addr + 1..16 data bytes per csn window.
// Ports: clk, rstn, bus (host if), csn/sclk/mosi out, miso in.
module spi_master #(
  parameter int CLK_DIV  = 2,
  parameter int CSN_IDLE = 2
) (
  input  logic        clk,
  input  logic        rstn,
  spi_master_if.slave bus,
  output logic        csn,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int CW = 16;
  localparam logic [CW-1:0] DIV_LAST =
    CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'((CSN_IDLE > 1) ? CSN_IDLE - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, SETUP, SCK_H, SCK_L, HOLD, GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    bit_q, bit_d;
  logic [7:0]    nbits_q, nbits_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rw_q, rw_d;
  logic          csn_q, csn_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wack_q, wack_d;
  logic          rvld_q, rvld_d;

  logic          tick;
  logic          rise;
  logic          fall;
  logic [7:0]    bit_nx;
  logic [7:0]    cmd;
  logic [7:0]    byte_nx;
  logic [3:0]    len_eff;

  assign tick   = (cnt_q == DIV_LAST);
  assign bit_nx = bit_q + 8'd1;

  always_comb begin
    unique case ({bus.rw, bus.burst})
      2'b00:   cmd = 8'hC1;
      2'b01:   cmd = 8'hC5;
      2'b10:   cmd = 8'hC2;
      default: cmd = 8'hCA;
    endcase
  end

  assign len_eff = bus.burst ? bus.len : 4'd0;

  // Byte entering mosi at a byte boundary:
  // addr after the cmd byte, then wdata (write)
  // or zeros (read).
  always_comb begin
    byte_nx = 8'h00;
    if (bit_q == 8'd8) begin
      byte_nx = addr_q;
    end else if (rw_q) begin
      byte_nx = bus.wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    nbits_d = nbits_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    csn_d   = csn_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wack_d  = 1'b0;
    rvld_d  = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = SETUP;
          busy_d  = 1'b1;
          csn_d   = 1'b0;
          rw_d    = bus.rw;
          addr_d  = bus.addr;
          nbits_d = 8'd24 + {1'b0, len_eff, 3'b000};
          bit_d   = 8'd0;
          mosi_d  = cmd[7];
          tx_d    = {cmd[6:0], 1'b0};
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SCK_H;
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rise    = 1'b1;
        end
      end
      SCK_H: begin
        if (tick) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == nbits_q) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
          end else begin
            state_d = SCK_L;
            fall    = 1'b1;
          end
        end
      end
      SCK_L: begin
        if (tick) begin
          state_d = SCK_H;
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rise    = 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = GAP;
          cnt_d   = '0;
          csn_d   = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // miso sampled as sclk rises; a read byte
    // completes on every 8th data-bit sample.
    if (rise) begin
      bit_d = bit_nx;
      rx_d  = {rx_q[6:0], miso};
      if (!rw_q && bit_nx > 8'd16 &&
          bit_nx[2:0] == 3'd0) begin
        rdata_d = {rx_q[6:0], miso};
        rvld_d  = 1'b1;
      end
    end

    // Next mosi bit driven as sclk falls.
    if (fall) begin
      if (bit_q[2:0] == 3'd0) begin
        mosi_d = byte_nx[7];
        tx_d   = {byte_nx[6:0], 1'b0};
        wack_d = rw_q && (bit_q >= 8'd16);
      end else begin
        mosi_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      nbits_q <= '0;
      addr_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wack_q  <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      nbits_q <= nbits_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      csn_q   <= csn_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wack_q  <= wack_d;
      rvld_q  <= rvld_d;
    end
  end

  assign csn           = csn_q;
  assign sclk          = sclk_q;
  assign mosi          = mosi_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wdata_ack = wack_q;
  assign bus.rdata     = rdata_q;
  assign bus.rdata_vld = rvld_q;

endmodule

// File: doc/spi_master.md
# spi_master

Host-side SPI initiator that drives the slave register-file interface: builds command, address and data frames, and transfers write data or collects read data. It sits between a local controller (test sequencer or CPU bridge) and the chip-level csn/sclk/mosi/miso pins. It uses SPI mode 0, MSB first, and one csn-low window per transaction. It supports single and burst reads and writes of 1–16 data bytes.

## Interface
- CLK_DIV, 2: sclk half-period in clk cycles; legal range ≥1.
- CSN_IDLE, 2: minimum csn-high clk cycles after each transaction before busy drops.
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  transaction request; accepted only when busy=0.
- rw  in  1  1=write, 0=read; sampled with start.
- burst  in  1  1=burst command; sampled with start.
- len  in  4  data bytes minus 1 (0→1 byte, 15→16 bytes); ignored (forced 0) when burst=0.
- addr  in  8  start register address; sampled with start.
- wdata  in  8  write byte; sampled when each data byte is loaded.
- wdata_ack  out  1  one-cycle pulse: wdata latched, present next byte.
- rdata  out  8  last received data byte; holds until next byte.
- rdata_vld  out  1  one-cycle pulse: rdata updated.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at end of transaction.
- csn  out  1  SPI chip select, active low.
- sclk  out  1  SPI clock, idles low.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.

## Operation
- Command byte: read single 8'hC1, read burst 8'hC5, write single 8'hC2, write burst 8'hCA.
- Frame: cmd byte, addr byte, then n=len+1 data bytes. Total bits N=16+8n (max 144). Bit counter is 8 bits wide.
- Read: mosi=0 during data bytes. Each data byte is shifted in from miso MSB first.
- Write: data bytes come from wdata, MSB first.
- FSM states: IDLE → SETUP → SCK_H ↔ SCK_L → HOLD → GAP → IDLE.
- IDLE: csn=1, sclk=0, mosi=0. On start=1, latch all fields and enter SETUP.
- SETUP: csn=0, mosi=cmd[7]. Lasts CLK_DIV cycles, then enter SCK_H.
- SCK_H: sclk=1 for CLK_DIV cycles. miso is sampled on the clk edge where sclk goes 0→1.
- SCK_L: sclk=0 for CLK_DIV cycles. mosi advances to the next bit on the clk edge where sclk goes 1→0.
- After the N-th high phase, sclk goes low and the FSM enters HOLD instead of SCK_L.
- HOLD: csn=0 for CLK_DIV cycles, then csn=1 and enter GAP.
- GAP: csn=1 for CSN_IDLE cycles. Then busy=0 and done=1 for one cycle; return to IDLE.
- Write byte load: wdata is latched on the edge that drives data bit 7 onto mosi (end of the addr byte, or after bit 0 of the previous data byte). wdata_ack pulses in the following cycle.
- Read byte complete: rdata and rdata_vld are registered on the sampling edge of data bit 0 of each byte, so n pulses per read.
- start while busy=1: ignored, no queuing.
- Reset (async, any state): csn=1, sclk=0, mosi=0, busy=0, done=0, wdata_ack=0, rdata_vld=0, rdata=8'h00, FSM in IDLE. A reset mid-transaction raises csn immediately and aborts the slave frame.

## Timing
- Edge E0 accepts start. Also at E0: busy←1, csn←0, mosi←cmd[7].
- First sclk rise: E0+CLK_DIV. k-th rise (k=1..N): E0+(2k−1)·CLK_DIV.
- Bit period: 2·CLK_DIV clk cycles.
- Last sclk fall: E0+2N·CLK_DIV.
- csn rise: E0+(2N+1)·CLK_DIV.
- busy fall and done pulse: E0+(2N+1)·CLK_DIV+CSN_IDLE.
- Next start is accepted on the edge where busy is 0; back-to-back transactions are allowed.
- mosi is stable ≥CLK_DIV cycles before and after every sclk rise. The slave shifts miso on sclk fall, so miso is stable at the master sample point.
- Host wdata window: the next byte must be valid within 16·CLK_DIV cycles after wdata_ack.

## Test plan
- Single write, CLK_DIV=2, CSN_IDLE=2, addr=8'h12, wdata=8'hA5 → mosi bits C2,12,A5; 24 sclk pulses; one wdata_ack; done at E0+100; slave register 12h=A5.
- Single read, addr 8'h34, slave returns 8'h5A → mosi bits C1,34,00; one rdata_vld with rdata=8'h5A; csn low for 98 cycles.
- Burst write, len=3, addr 8'h10, data 01,02,03,04 → cmd CA; 48 sclk pulses; four wdata_ack pulses spaced 32 cycles apart; slave registers 10h–13h = 01..04.
- Burst read, len=15 (16 bytes) → cmd C5; 144 sclk pulses; 16 rdata_vld pulses with rdata matching slave addresses addr..addr+15.
- rstn asserted at mid-address (bit 12) → csn=1, sclk=0, busy=0 asynchronously; no done pulse; a following single write completes normally.
- start held high continuously with CLK_DIV=1, CSN_IDLE=1 → back-to-back transactions; csn high for exactly 2 cycles between frames (HOLD ends, GAP of 1, new SETUP); start pulses while busy=1 have no effect.
